// File: rtl/opfetch_pkg.sv
// Shared types and constants for the operand fetch stage.
package opfetch_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

endpackage

// File: rtl/opfetch_bypass.sv
// Per-operand writeback snoop: pending copy, capture mux, stall refresh.
module opfetch_bypass
  import opfetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  state_t            state_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_rd_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ex_ready_i,
  output logic [DATA_W-1:0] op_o
);

  logic              is_zero;
  logic              hit;
  logic              pend_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] cap_val;

  assign is_zero = (addr_i == ADDR_W'(REG_ZERO));
  assign hit     = wb_we_i && (wb_addr_i == addr_i) && !is_zero;

  always_comb begin
    cap_val = rf_rd_i;
    if (is_zero)     cap_val = '0;
    else if (hit)    cap_val = wb_data_i;
    else if (pend_q) cap_val = pend_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      op_q        <= '0;
    end else begin
      unique case (state_i)
        FETCH: begin
          // RF hands back pre-write data for a write in this cycle
          if (hit) begin
            pend_q      <= 1'b1;
            pend_data_q <= wb_data_i;
          end
        end
        CAPTURE: op_q <= cap_val;
        VALID: begin
          if (ex_ready_i) pend_q <= 1'b0;
          else if (hit)   op_q   <= wb_data_i;
        end
        default: ;
      endcase
    end
  end

  assign op_o = op_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read latency absorb + writeback bypass.
// Optional stall counter output under `OPFETCH_PERF_EN.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [ADDR_W-1:0] dec_rs_i,
  input  logic [ADDR_W-1:0] dec_rt_i,
  input  logic [ADDR_W-1:0] dec_rd_i,
  input  logic              dec_we_i,
  output logic [ADDR_W-1:0] rf_addr1_o,
  output logic [ADDR_W-1:0] rf_addr2_o,
  input  logic [DATA_W-1:0] rf_rd1_i,
  input  logic [DATA_W-1:0] rf_rd2_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [DATA_W-1:0] ex_op1_o,
  output logic [DATA_W-1:0] ex_op2_o,
  output logic [ADDR_W-1:0] ex_rd_o,
`ifdef OPFETCH_PERF_EN
  output logic [31:0]       perf_stall_cnt_o,
`endif
  output logic              ex_we_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic              we_q;
  logic              accept;

  assign dec_ready_o = (state_q == IDLE);
  assign accept      = dec_valid_i && dec_ready_o;
  assign ex_valid_o  = (state_q == VALID);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = VALID;
      VALID:   if (ex_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs_q <= dec_rs_i;
        rt_q <= dec_rt_i;
        rd_q <= dec_rd_i;
        we_q <= dec_we_i;
      end
    end
  end

  assign rf_addr1_o = rs_q;
  assign rf_addr2_o = rt_q;
  assign ex_rd_o    = rd_q;
  assign ex_we_o    = we_q;

  opfetch_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .state_i    (state_q),
    .addr_i     (rs_q),
    .rf_rd_i    (rf_rd1_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .ex_ready_i (ex_ready_i),
    .op_o       (ex_op1_o)
  );

  opfetch_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp2 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .state_i    (state_q),
    .addr_i     (rt_q),
    .rf_rd_i    (rf_rd2_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .ex_ready_i (ex_ready_i),
    .op_o       (ex_op2_o)
  );

`ifdef OPFETCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (ex_valid_o && !ex_ready_i && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Initiator/reader side of the MIPS register file. Accepts one decoded instruction at a time and issues its rs/rt addresses to the register-file read ports.
- The register file has a registered one-cycle read, so this block absorbs that latency. It also bypasses same-cycle and in-flight writeback data.
- Delivers coherent operands to the execute stage over a valid/ready handshake.

Parameters:
DATA_W, 32, operand/register width
ADDR_W, 5, register index width (32 registers)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
dec_valid_i  in  1  decode offers instruction
dec_ready_o  out  1  block can accept instruction
dec_rs_i  in  ADDR_W  source register 1 index
dec_rt_i  in  ADDR_W  source register 2 index
dec_rd_i  in  ADDR_W  destination index, passed through
dec_we_i  in  1  destination write enable, passed through
rf_addr1_o  out  ADDR_W  register-file read address 1
rf_addr2_o  out  ADDR_W  register-file read address 2
rf_rd1_i  in  DATA_W  register-file read data 1, valid one cycle after address sampled
rf_rd2_i  in  DATA_W  register-file read data 2
wb_we_i  in  1  writeback write enable (same signal driven to register-file write port)
wb_addr_i  in  ADDR_W  writeback address
wb_data_i  in  DATA_W  writeback data
ex_valid_o  out  1  operands valid
ex_ready_i  in  1  execute accepts
ex_op1_o  out  DATA_W  operand for rs
ex_op2_o  out  DATA_W  operand for rt
ex_rd_o  out  ADDR_W  destination index
ex_we_o  out  1  destination write enable

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i asynchronous active-high. Reset clears all registers to 0 and forces state IDLE; any in-flight instruction is dropped.
- Output reset values: ex_valid_o=0, ex_op1_o=0, ex_op2_o=0, ex_rd_o=0, ex_we_o=0, rf_addr1_o=0, rf_addr2_o=0. dec_ready_o=1, since it is combinational (state==IDLE).
- FSM states: IDLE, FETCH, CAPTURE, VALID.
- IDLE: on dec_valid_i&&dec_ready_o, latch rs/rt/rd/we and go to FETCH. rf_addr*_o are driven from the latched rs/rt registers.
- FETCH: the register file samples the addresses at the end of this cycle.
  - If wb_we_i and wb_addr_i==rs (rs!=0), set pend1 and store wb_data_i. Same for rt into pend2.
  - The register file returns pre-write data for this write, so the pending copy is required.
  - Go to CAPTURE.
- CAPTURE: op1 takes the first match in this priority order:
  - 0 if rs==0;
  - else wb_data_i if wb_we_i&&wb_addr_i==rs;
  - else pend1 data if pend1;
  - else rf_rd1_i.
  - op2 uses the same rule with rt. Go to VALID and set ex_valid_o.
- VALID: ex_valid_o=1.
  - Each edge with ex_ready_i=0: a matching nonzero writeback overwrites the held operand, so operands stay coherent while stalled.
  - Edge with ex_ready_i=1: clear ex_valid_o and pend flags, go to IDLE.
- Latency: accept edge E0 -> ex_valid_o high after E2. Throughput is 1 instruction per 4 cycles when ex_ready_i is held 1.
- Register 0 always yields 0 regardless of register-file contents or writeback to address 0.
- If rs==rt, both operands receive identical values, including bypass.
- dec_ready_o is low in FETCH, CAPTURE and VALID; decode must hold its inputs stable.

Optional Feature:
OPFETCH_PERF_EN
- Defined: adds output perf_stall_cnt_o (32 bits, reset 0). It increments every cycle ex_valid_o&&!ex_ready_i and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package opfetch_pkg holds:
  - state enum type (IDLE, FETCH, CAPTURE, VALID);
  - localparam REG_ZERO = 5'd0;
  - default DATA_W/ADDR_W constants.
- Sub-module opfetch_bypass: one per operand, instantiated twice. It holds the pend flag and data, performs the capture priority mux and the hold-time snoop update, and is driven by state and the snoop bus.

Test Plan:
- Reg n preloaded with n: dec rs=3, rt=5, rd=7, we=1, ex_ready_i=1 -> ex_valid_o high 2 cycles after accept; op1=0x3, op2=0x5, ex_rd_o=7, ex_we_o=1; dec_ready_o high again the cycle after handoff.
- Prior write reg0=0xFFFF; dec rs=0, rt=0 -> op1=0, op2=0.
- wb write reg3=0xDEAD during FETCH, rs=3 -> op1=0xDEAD (register file itself returned 0x3).
- wb reg5=0x1111 in FETCH, then reg5=0xBEEF in CAPTURE, rt=5 -> op2=0xBEEF.
- ex_ready_i low 4 cycles in VALID; wb reg3=0xCAFE in the 2nd hold cycle -> op1 changes to 0xCAFE; dec_ready_o low throughout. With OPFETCH_PERF_EN, perf_stall_cnt_o=4.
- Assert rst_i mid-FETCH -> ex_valid_o stays 0, dec_ready_o=1 immediately, state IDLE; next accepted instruction completes normally.
